// File: rtl/ysyx_23060332_mc_ctrl.sv
// Multi-cycle core sequencer: owns the PC and steps fetch/exec/mem/commit over valid/ready handshakes.
// Optional cycle/instret counters are built only when YSYX_23060332_PERF_CNT_EN is defined.
module ysyx_23060332_mc_ctrl #(
   parameter int              XLEN           = 64,
   parameter logic [XLEN-1:0] RESET_PC       = XLEN'(64'h8000_0000),
   parameter int              TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            rst,
   output logic            ifu_req_valid,
   input  logic            ifu_req_ready,
   output logic [XLEN-1:0] ifu_addr,
   input  logic            ifu_rsp_valid,
   output logic            ifu_rsp_ready,
   input  logic [31:0]     ifu_rsp_inst,
   output logic [31:0]     inst_o,
   output logic [XLEN-1:0] inst_addr_o,
   input  logic            exu_jump_en,
   input  logic [XLEN-1:0] exu_jump_addr,
   input  logic            exu_is_load,
   input  logic            exu_is_store,
   input  logic            exu_reg_wen,
   input  logic            ebreak_i,
   output logic            lsu_req_valid,
   input  logic            lsu_req_ready,
   input  logic            lsu_rsp_valid,
   output logic            reg_wen_o,
   output logic            commit,
   output logic [XLEN-1:0] pc_o,
   output logic            halted,
   output logic            timeout_err,
   output logic [63:0]     perf_cycle,
   output logic [63:0]     perf_instret
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE, FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, HALT
   } state_t;

   state_t          state;
   logic [WD_W-1:0] wd;
   logic            is_mem;
   logic            waiting;
   logic            handshake;
   logic            expire;
   logic            exec_commit;
   logic            mem_commit;
   logic [XLEN-1:0] pc_next;

   assign is_mem    = exu_is_load | exu_is_store;
   assign waiting   = (state == FETCH_REQ) || (state == FETCH_WAIT) ||
                      (state == MEM_REQ)   || (state == MEM_WAIT);
   assign handshake = ((state == FETCH_REQ)  && ifu_req_ready) ||
                      ((state == FETCH_WAIT) && ifu_rsp_valid) ||
                      ((state == MEM_REQ)    && lsu_req_ready) ||
                      ((state == MEM_WAIT)   && lsu_rsp_valid);
   // A handshake in the expiry cycle wins, so the watchdog only fires on a genuinely idle cycle.
   assign expire    = waiting && !handshake && (wd == WD_W'(TIMEOUT_CYCLES - 1));

   assign exec_commit = (state == EXEC) && (ebreak_i || !is_mem);
   assign mem_commit  = (state == MEM_WAIT) && lsu_rsp_valid;

   // Jump targets are forced halfword-aligned; bit 1 passes through untrapped.
   assign pc_next = exu_jump_en ? (exu_jump_addr & ~XLEN'(1)) : (pc_o + XLEN'(4));

   assign ifu_req_valid = (state == FETCH_REQ);
   assign ifu_rsp_ready = (state == FETCH_WAIT);
   assign lsu_req_valid = (state == MEM_REQ);
   assign halted        = (state == HALT);
   assign ifu_addr      = pc_o;

   assign commit    = !rst && (exec_commit || mem_commit);
   assign reg_wen_o = !rst && ((exec_commit && !ebreak_i && exu_reg_wen) ||
                               (mem_commit && exu_reg_wen && exu_is_load));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc_o        <= RESET_PC;
         inst_o      <= '0;
         inst_addr_o <= RESET_PC;
         timeout_err <= 1'b0;
         wd          <= '0;
      end else begin
         wd <= (waiting && !handshake) ? wd + WD_W'(1) : '0;
         if (expire) begin
            timeout_err <= 1'b1;
            state       <= HALT;
            wd          <= '0;
         end else begin
            case (state)
               IDLE:       state <= FETCH_REQ;
               FETCH_REQ:  if (ifu_req_ready) state <= FETCH_WAIT;
               FETCH_WAIT: if (ifu_rsp_valid) begin
                  inst_o      <= ifu_rsp_inst;
                  inst_addr_o <= pc_o;
                  state       <= EXEC;
               end
               EXEC: begin
                  if (ebreak_i) begin
                     state <= HALT;
                  end else if (is_mem) begin
                     state <= MEM_REQ;
                  end else begin
                     pc_o  <= pc_next;
                     state <= FETCH_REQ;
                  end
               end
               MEM_REQ:    if (lsu_req_ready) state <= MEM_WAIT;
               MEM_WAIT:   if (lsu_rsp_valid) begin
                  pc_o  <= pc_next;
                  state <= FETCH_REQ;
               end
               HALT:       state <= HALT;
               default:    state <= HALT;
            endcase
         end
      end
   end

`ifdef YSYX_23060332_PERF_CNT_EN
   logic [63:0] cyc_cnt;
   logic [63:0] ret_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt <= '0;
         ret_cnt <= '0;
      end else begin
         if (state != HALT) cyc_cnt <= cyc_cnt + 64'd1;
         if (commit)        ret_cnt <= ret_cnt + 64'd1;
      end
   end

   assign perf_cycle   = cyc_cnt;
   assign perf_instret = ret_cnt;
`else
   assign perf_cycle   = '0;
   assign perf_instret = '0;
`endif

endmodule
